// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle for the sequential restoring divider.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] ans;
   logic [WIDTH-1:0] rem;
   logic             div_by_zero;

   modport master (
      output start, a, b,
      input  busy, done, ans, rem, div_by_zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, ans, rem, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per cycle.
// An accepted request spends one armed cycle in IDLE, then WIDTH cycles in RUN, then one in DONE.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   seq_divider_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic             armed;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] prem;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] ans_q;
   logic [WIDTH-1:0] rem_q;
   logic             dbz_q;

   logic             accept;
   logic             last_step;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qbit;
   logic [WIDTH-1:0] prem_next;
   logic [WIDTH-1:0] quo_next;

   // armed blocks a second acceptance while the latched operands wait to launch
   assign accept    = bus.start && (state != RUN) && !armed;
   assign last_step = (state == RUN) && (cnt == CW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (armed) begin
               state_next = (dvs == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state == RUN);
      bus.done        = (state == DONE);
      bus.ans         = ans_q;
      bus.rem         = rem_q;
      bus.div_by_zero = dbz_q;
   end

   // dividend register doubles as the quotient shift register
   always_comb begin
      shifted   = {prem, dvd[WIDTH-1]};
      diff      = shifted - {1'b0, dvs};
      qbit      = ~diff[WIDTH];
      prem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_next  = {dvd[WIDTH-2:0], qbit};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed <= 1'b0;
         dvd   <= '0;
         dvs   <= '0;
         prem  <= '0;
         cnt   <= '0;
         ans_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         armed <= accept;
         if (accept) begin
            dvd  <= bus.a;
            dvs  <= bus.b;
            prem <= '0;
            cnt  <= CW'(WIDTH);
         end else if (state == RUN) begin
            dvd  <= quo_next;
            prem <= prem_next;
            cnt  <= cnt - CW'(1);
         end
         if ((state == IDLE) && armed && (dvs == '0)) begin
            ans_q <= '1;
            rem_q <= dvd;
            dbz_q <= 1'b1;
         end else if (last_step) begin
            ans_q <= quo_next;
            rem_q <= prem_next;
            dbz_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - bench for seq_divider: timing/result model plus directed, sweep and random runs.
module tb_seq_divider;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(W)) bus ();
   seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an op accepted at edge k finishes at edge k+W+1 (or k+1 for b=0);
   // requests are refused from edge k+1 through the finishing edge.
   int ecount = 0;
   bit op = 0;
   bit op_zero = 0;
   int k_edge = 0;
   int d_edge = 0;
   int r_ans = 0, r_rem = 0;
   bit r_dbz = 0;
   int m_ans = 0, m_rem = 0;
   bit m_dbz = 0, m_busy = 0, m_done = 0;
   bit chk_on = 0;

   always @(posedge clk) begin
      ecount++;
      if (reset) begin
         op = 0; m_ans = 0; m_rem = 0; m_dbz = 0; m_busy = 0; m_done = 0;
      end else begin
         if (op && ecount == d_edge) begin
            m_ans = r_ans; m_rem = r_rem; m_dbz = r_dbz;
         end
         if (bus.start && (!op || ecount > d_edge)) begin
            op = 1;
            k_edge = ecount;
            op_zero = (bus.b == 0);
            d_edge = ecount + (op_zero ? 1 : W + 1);
            r_ans = op_zero ? (1 << W) - 1 : int'(bus.a) / int'(bus.b);
            r_rem = op_zero ? int'(bus.a) : int'(bus.a) % int'(bus.b);
            r_dbz = op_zero;
         end
         m_busy = op && !op_zero && ecount >= k_edge + 1 && ecount <= k_edge + W;
         m_done = op && ecount == d_edge;
      end
   end

   always @(negedge clk) begin
      if (chk_on && !reset) begin
         cmp("busy", bus.busy, m_busy);
         cmp("done", bus.done, m_done);
         cmp("ans", bus.ans, m_ans);
         cmp("rem", bus.rem, m_rem);
         cmp("div_by_zero", bus.div_by_zero, m_dbz);
      end
   end

   task automatic do_op(input int x, input int y, output int q, output int r, output int z, output int lat);
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'(x); bus.b = 4'(y);
      @(negedge clk);
      bus.start = 1'b0; bus.a = 4'($urandom_range(0, 15)); bus.b = 4'($urandom_range(0, 15));
      lat = 1;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.done) begin
         n_cmp++; n_bad++;
         $display("FAIL op_timeout: got no done expected done for %0d/%0d", x, y);
      end
      q = bus.ans; r = bus.rem; z = bus.div_by_zero;
   endtask

   initial begin
      int q, r, z, lat, nd, last, cnt_d;
      logic [5:0] bseq, dseq;
      bus.start = 1'b0; bus.a = '0; bus.b = '0;

      repeat (2) @(negedge clk);
      cmp("rst_busy", bus.busy, 0);
      cmp("rst_done", bus.done, 0);
      cmp("rst_ans", bus.ans, 0);
      cmp("rst_rem", bus.rem, 0);
      cmp("rst_dbz", bus.div_by_zero, 0);
      @(negedge clk);
      reset = 1'b0;
      chk_on = 1'b1;

      // 13/4 cycle-by-cycle
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd13; bus.b = 4'd4;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 4'd2; bus.b = 4'd9;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         bseq[i] = bus.busy;
         dseq[i] = bus.done;
      end
      cmp("t13_busy_seq", int'(bseq), 6'b011110);
      cmp("t13_done_seq", int'(dseq), 6'b100000);
      cmp("t13_ans", bus.ans, 3);
      cmp("t13_rem", bus.rem, 1);
      cmp("t13_dbz", bus.div_by_zero, 0);
      cmp("model_ans_13_4", m_ans, 3);
      cmp("model_rem_13_4", m_rem, 1);

      do_op(9, 0, q, r, z, lat);
      cmp("z9_lat", lat, 2); cmp("z9_ans", q, 15); cmp("z9_rem", r, 9); cmp("z9_dbz", z, 1);
      do_op(15, 1, q, r, z, lat);
      cmp("d15_1_lat", lat, 6); cmp("d15_1_ans", q, 15); cmp("d15_1_rem", r, 0); cmp("d15_1_dbz", z, 0);
      do_op(3, 7, q, r, z, lat);
      cmp("d3_7_ans", q, 0); cmp("d3_7_rem", r, 3);
      do_op(15, 15, q, r, z, lat);
      cmp("d15_15_ans", q, 1); cmp("d15_15_rem", r, 0);

      // second request during RUN is dropped
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd13; bus.b = 4'd4;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) begin
            nd++; q = bus.ans; r = bus.rem;
         end
      end
      cmp("drop_count", nd, 1); cmp("drop_ans", q, 3); cmp("drop_rem", r, 1);

      // reset mid-RUN
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd14; bus.b = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      cmp("arst_busy", bus.busy, 0);
      cmp("arst_done", bus.done, 0);
      cmp("arst_ans", bus.ans, 0);
      cmp("arst_rem", bus.rem, 0);
      cmp("arst_dbz", bus.div_by_zero, 0);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      cmp("arst_no_done", nd, 0);
      do_op(14, 3, q, r, z, lat);
      cmp("d14_3_lat", lat, 6); cmp("d14_3_ans", q, 4); cmp("d14_3_rem", r, 2);

      // start held high
      @(negedge clk);
      bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd5;
      last = -1; cnt_d = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) begin
            cnt_d++;
            cmp("cont_ans", bus.ans, 2);
            cmp("cont_rem", bus.rem, 2);
            if (last >= 0) cmp("cont_gap", i - last, 6);
            last = i;
         end
      end
      bus.start = 1'b0;
      cmp("cont_count", cnt_d, 6);
      repeat (8) @(negedge clk);

      // exhaustive sweep
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            do_op(x, y, q, r, z, lat);
            if (y == 0) begin
               cmp("sweep_z_lat", lat, 2);
               cmp("sweep_z_ans", q, 15);
               cmp("sweep_z_rem", r, x);
               cmp("sweep_z_dbz", z, 1);
            end else begin
               cmp("sweep_lat", lat, 6);
               cmp("sweep_identity", q * y + r, x);
               cmp("sweep_rem_lt_b", int'(r < y), 1);
               cmp("sweep_dbz", z, 0);
            end
         end
      end

      // random traffic with occasional reset
      repeat (3000) begin
         @(negedge clk);
         reset = ($urandom_range(0, 399) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         bus.a = 4'($urandom_range(0, 15));
         bus.b = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      reset = 1'b0; bus.start = 1'b0;
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  unsigned dividend; sampled when start is accepted.
REQ-006 b  input  WIDTH  unsigned divisor; sampled when start is accepted.
REQ-007 busy  output  1  high while a division is iterating.
REQ-008 done  output  1  one-cycle pulse marking a new valid result.
REQ-009 ans  output  WIDTH  registered quotient.
REQ-010 rem  output  WIDTH  registered remainder.
REQ-011 div_by_zero  output  1  registered flag; high when the last accepted divisor was 0.

Function
REQ-012 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE; start in RUN SHALL be ignored, and a, b and the internal state SHALL stay unaffected.
REQ-014 On acceptance with b!=0, the block SHALL latch a and b internally, clear the partial remainder, load the iteration counter with WIDTH, and enter RUN on the next edge.
REQ-015 RUN SHALL perform one restoring step per cycle, MSB first:
- shift {partial remainder, dividend} left by 1;
- trial-subtract the divisor using a (WIDTH+1)-bit difference;
- if non-negative, keep the difference and set the quotient bit to 1;
- otherwise, restore the remainder and set the quotient bit to 0.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the final step, ans and rem SHALL be updated and the state SHALL go to DONE.
REQ-017 Latency: with start accepted at edge k, done SHALL be high during the cycle after edge k+WIDTH+1, and low at all other times.
REQ-018 busy SHALL be 1 exactly while in RUN.
REQ-019 done SHALL be 1 exactly while in DONE; DONE SHALL last one cycle and return to IDLE unless start is accepted in that same cycle.
REQ-020 Start accepted in DONE SHALL begin a new division, back-to-back with no idle cycle.
REQ-021 On acceptance with b=0, the block SHALL go directly to DONE on the next edge and SHALL set ans=all ones, rem=a and div_by_zero=1.
REQ-022 div_by_zero SHALL clear to 0 when a division with b!=0 completes.
REQ-023 ans, rem and div_by_zero SHALL hold their values from the last completion until the next completion or reset; they SHALL not change during RUN.
REQ-024 Results SHALL satisfy a = ans*b + rem with rem < b for every b!=0 and all 2^(2*WIDTH) operand pairs.
REQ-025 Changes on a and b after acceptance SHALL not affect the running division.

Reset
REQ-026 While reset=1, the block SHALL be forced immediately, without waiting for clk, to: state IDLE, busy=0, done=0, ans=0, rem=0, div_by_zero=0, and internal registers cleared.
REQ-027 Reset asserted mid-RUN SHALL abort the division; no done pulse SHALL follow for the aborted operation.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=4)
REQ-029 a=13, b=4, start pulse at edge k -> busy=1 for edges k+1..k+4; done=1 for one cycle after edge k+5 with ans=3, rem=1, div_by_zero=0.
REQ-030 a=9, b=0 -> done one cycle after acceptance; ans=15, rem=9, div_by_zero=1; a following 15/1 -> ans=15, rem=0, div_by_zero=0.
REQ-031 a=3, b=7 -> ans=0, rem=3; a=15, b=15 -> ans=1, rem=0.
REQ-032 Start 13/4, then start=1 with a=1, b=1 two cycles later while busy -> single result ans=3, rem=1; the second request is dropped.
REQ-033 Start 14/3, assert reset after 2 RUN cycles -> all outputs 0 immediately, asynchronously; no done pulse; then 14/3 -> ans=4, rem=2.
REQ-034 Start held high continuously with 12/5 -> results every 6 cycles, each ans=2, rem=2; done pulses never adjacent.
REQ-035 The bench SHALL run an exhaustive sweep of all 256 operand pairs, checked against REQ-021/REQ-024.
